// File: rtl/mma_bus_pkg.sv
// Shared types and constants for the MMA internal memory bus.
// Holds the bus-master FSM state type, I/O port addresses and the read-only port test.
package mma_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } bus_state_e;

  localparam logic [15:0] ADDR_PSW   = 16'h0FFB;
  localparam logic [15:0] ADDR_PORTA = 16'h0FFC;
  localparam logic [15:0] ADDR_PORTB = 16'h0FFD;
  localparam logic [15:0] ADDR_PORTC = 16'h0FFE;
  localparam logic [15:0] ADDR_PORTD = 16'h0FFF;

  // portb and portd are input ports; writing them is an error.
  function automatic logic is_ro_port(input logic [15:0] addr);
    return (addr == ADDR_PORTB) || (addr == ADDR_PORTD);
  endfunction

endpackage

// File: rtl/mem_bus_arb.sv
// Two-way round-robin arbiter: bit 0 = fetch, bit 1 = data.
// On a tie the requester not granted last wins; reset leaves data as last grant.
module mem_bus_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_data_q;
  logic last_data_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_data_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_data_d = last_data_q;
    if (update && (req != 2'b00)) begin
      last_data_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Memory bus initiator: arbitrates fetch and data requests onto int_abus/int_wbus/we
// and captures int_rbus one cycle after the address is taken by memory.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no transaction; a pending request is granted and latched
//   ST_ACCESS | bus driven one cycle; we high for a legal write
//   ST_WAIT   | read only; int_rbus valid, captured into rdata
//   ST_ACK    | one-cycle ack to the granted requester
module mem_bus_master
  import mma_bus_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_ack,
  output logic          data_err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          we,
  output logic [AW-1:0] int_abus,
  output logic [DW-1:0] int_wbus,
  input  logic [DW-1:0] int_rbus
);

  bus_state_e    state_q, state_d;
  logic [AW-1:0] int_abus_q, int_abus_d;
  logic [DW-1:0] int_wbus_q, int_wbus_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt_data_q, gnt_data_d;
  logic          wr_q, wr_d;
  logic          ro_q, ro_d;
  logic [1:0]    gnt;

  mem_bus_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({data_req, fetch_req}),
    .update (state_q == ST_IDLE),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      int_abus_q <= '0;
      int_wbus_q <= '0;
      rdata_q    <= '0;
      gnt_data_q <= 1'b0;
      wr_q       <= 1'b0;
      ro_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_abus_q <= int_abus_d;
      int_wbus_q <= int_wbus_d;
      rdata_q    <= rdata_d;
      gnt_data_q <= gnt_data_d;
      wr_q       <= wr_d;
      ro_q       <= ro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fetch_req || data_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = wr_q ? ST_ACK : ST_WAIT;
      ST_WAIT:   state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transaction latch in IDLE; fetch leaves int_wbus untouched since it never writes.
  always_comb begin
    int_abus_d = int_abus_q;
    int_wbus_d = int_wbus_q;
    rdata_d    = rdata_q;
    gnt_data_d = gnt_data_q;
    wr_d       = wr_q;
    ro_d       = ro_q;
    if ((state_q == ST_IDLE) && (gnt != 2'b00)) begin
      gnt_data_d = gnt[1];
      if (gnt[1]) begin
        int_abus_d = data_addr;
        int_wbus_d = data_wdata;
        wr_d       = data_we;
        ro_d       = data_we && is_ro_port(data_addr);
      end else begin
        int_abus_d = fetch_addr;
        wr_d       = 1'b0;
        ro_d       = 1'b0;
      end
    end
    if (state_q == ST_WAIT) begin
      rdata_d = int_rbus;
    end
  end

  always_comb begin
    we        = (state_q == ST_ACCESS) && wr_q && !ro_q;
    busy      = (state_q != ST_IDLE);
    fetch_ack = (state_q == ST_ACK) && !gnt_data_q;
    data_ack  = (state_q == ST_ACK) && gnt_data_q;
    data_err  = (state_q == ST_ACK) && gnt_data_q && ro_q;
  end

  assign int_abus = int_abus_q;
  assign int_wbus = int_wbus_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural memory, transaction-level reference model
// checked every cycle, plus directed literal cases and randomized two-requester traffic.
module tb_mem_bus_master;
  import mma_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] data_addr = '0;
  logic [15:0] data_wdata = '0;
  logic        fetch_ack, data_ack, data_err, busy, we;
  logic [15:0] rdata, int_abus, int_wbus, int_rbus;

  logic [15:0] mem [0:65535];
  logic [15:0] lat_addr;
  logic [15:0] portb = 16'h00AA;
  logic [15:0] portd = 16'h0055;

  int n_checks = 0;
  int n_err = 0;

  mem_bus_master #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_err(data_err), .rdata(rdata), .busy(busy), .we(we),
    .int_abus(int_abus), .int_wbus(int_wbus), .int_rbus(int_rbus)
  );

  always #5 clk = ~clk;

  // Memory stand-in: address latched every edge, read data one cycle later.
  initial begin
    lat_addr <= '0;
    for (int i = 0; i < 65536; i++) mem[16'(i)] <= '0;
    mem[16'h0100] <= 16'h0003;
    forever begin
      @(posedge clk);
      if (we) mem[int_abus] <= int_wbus;
      lat_addr <= int_abus;
    end
  end
  assign int_rbus = (lat_addr == ADDR_PORTB) ? portb :
                    (lat_addr == ADDR_PORTD) ? portd : mem[lat_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_ram [0:65535];
  int          cyc = 0;
  int          m_start, m_lat, m_idle_from;
  bit          m_active, m_gdata, m_wr, m_ro, m_last_data;
  logic [15:0] m_addr, m_wdata, m_rdata;
  bit          e_busy, e_we, e_fack, e_dack, e_err;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a == ADDR_PORTB) return portb;
    if (a == ADDR_PORTD) return portd;
    return m_ram[a];
  endfunction

  task automatic m_reset();
    m_active = 0; m_idle_from = cyc; m_last_data = 1;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_ro = 0; m_gdata = 0;
    e_busy = 0; e_we = 0; e_fack = 0; e_dack = 0; e_err = 0;
  endtask

  task automatic m_step();
    int k;
    cyc++;
    if (m_active && (cyc - m_start == m_lat + 1)) begin
      m_active = 0;
      m_idle_from = cyc;
    end
    if (!m_active && (cyc > m_idle_from) && (fetch_req || data_req)) begin
      m_gdata = (fetch_req && data_req) ? !m_last_data : data_req;
      m_last_data = m_gdata;
      if (m_gdata) begin
        m_addr = data_addr; m_wdata = data_wdata; m_wr = data_we;
        m_ro = data_we && ((data_addr == 16'h0FFD) || (data_addr == 16'h0FFF));
      end else begin
        m_addr = fetch_addr; m_wr = 0; m_ro = 0;
      end
      m_active = 1; m_start = cyc; m_lat = m_wr ? 1 : 2;
      if (m_wr && !m_ro) m_ram[m_addr] = m_wdata;
    end
    k = cyc - m_start;
    e_busy = m_active;
    e_we   = m_active && (k == 0) && m_wr && !m_ro;
    e_fack = m_active && (k == m_lat) && !m_gdata;
    e_dack = m_active && (k == m_lat) && m_gdata;
    e_err  = e_dack && m_ro;
    if (m_active && !m_wr && (k == 2)) m_rdata = model_read(m_addr);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) m_ram[16'(i)] = '0;
    m_ram[16'h0100] = 16'h0003;
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int f_ack_cnt = 0;
  int d_ack_cnt = 0;
  int glog[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("we", 32'(we), 32'(e_we));
      chk("fetch_ack", 32'(fetch_ack), 32'(e_fack));
      chk("data_ack", 32'(data_ack), 32'(e_dack));
      chk("data_err", 32'(data_err), 32'(e_err));
      chk("int_abus", 32'(int_abus), 32'(m_addr));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (e_we) chk("int_wbus", 32'(int_wbus), 32'(m_wdata));
      if (reset) chk("int_wbus_rst", 32'(int_wbus), 32'h0);
      if (m_active && !reset) chk("req_held", 32'(m_gdata ? data_req : fetch_req), 32'h1);
      if (fetch_ack) begin f_ack_cnt++; glog.push_back(0); end
      if (data_ack)  begin d_ack_cnt++; glog.push_back(1); end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic new_fetch();
    fetch_addr = ($urandom_range(0, 9) < 8) ? 16'h0200 + 16'($urandom_range(0, 7))
                                            : 16'h0FFB + 16'($urandom_range(0, 4));
  endtask

  task automatic new_data();
    data_we    = 1'($urandom_range(0, 1));
    data_addr  = ($urandom_range(0, 9) < 6) ? 16'h0200 + 16'($urandom_range(0, 7))
                                            : 16'h0FFB + 16'($urandom_range(0, 4));
    data_wdata = 16'($urandom);
  endtask

  task automatic run_single(input bit is_d, input bit wr, input logic [15:0] a,
                            input logic [15:0] wd, output int lat, output int we_n,
                            output logic [15:0] we_a, output logic [15:0] we_d,
                            output logic err, output logic [15:0] rd, output logic [15:0] pa);
    bit got = 0;
    lat = 0; we_n = 0; we_a = '0; we_d = '0; err = 0; rd = '0; pa = '0;
    @(posedge clk); #1;
    if (is_d) begin
      data_req = 1; data_we = wr; data_addr = a; data_wdata = wd;
    end else begin
      fetch_req = 1; fetch_addr = a; data_we = 1'b1;
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (we) begin we_n++; we_a = int_abus; we_d = int_wbus; end
      if (is_d ? data_ack : fetch_ack) begin
        got = 1; err = data_err; rd = rdata; pa = mem[ADDR_PORTA];
      end
    end
    chk("single_ack_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
    fetch_req = 0; data_req = 0; data_we = 0;
  endtask

  task automatic run_pair(input int nf, input int nd, input bit gaps);
    int f_left = nf, d_left = nd, f_gap = 0, d_gap = 0, budget = 0;
    int f_seen, d_seen;
    @(posedge clk); #1;
    f_seen = f_ack_cnt; d_seen = d_ack_cnt;
    if (f_left > 0) begin fetch_req = 1; new_fetch(); end
    if (d_left > 0) begin data_req = 1; new_data(); end
    while ((f_left > 0 || d_left > 0) && budget < 60 * (nf + nd) + 100) begin
      @(posedge clk); #1; budget++;
      if (f_ack_cnt != f_seen) begin
        f_seen = f_ack_cnt; f_left--;
        if (f_left > 0 && !(gaps && $urandom_range(0, 2) == 0)) new_fetch();
        else begin fetch_req = 0; f_gap = gaps ? $urandom_range(0, 3) : 0; end
      end else if (!fetch_req && f_left > 0) begin
        if (f_gap == 0) begin fetch_req = 1; new_fetch(); end
        else f_gap--;
      end
      if (d_ack_cnt != d_seen) begin
        d_seen = d_ack_cnt; d_left--;
        if (d_left > 0 && !(gaps && $urandom_range(0, 2) == 0)) new_data();
        else begin data_req = 0; d_gap = gaps ? $urandom_range(0, 3) : 0; end
      end else if (!data_req && d_left > 0) begin
        if (d_gap == 0) begin data_req = 1; new_data(); end
        else d_gap--;
      end
    end
    chk("pair_remaining", 32'(f_left + d_left), 32'h0);
    fetch_req = 0; data_req = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          lat, we_n, g0;
    logic [15:0] we_a, we_d, rd, pa;
    logic        err;
    bit          got;

    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_abus", 32'(int_abus), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    reset = 0;

    run_single(0, 0, 16'h0100, 16'h0, lat, we_n, we_a, we_d, err, rd, pa);
    chk("f0100_latency", lat, 3);
    chk("f0100_rdata", 32'(rd), 32'h0003);
    chk("f0100_we_cycles", we_n, 0);

    run_single(1, 1, 16'h0200, 16'hBEEF, lat, we_n, we_a, we_d, err, rd, pa);
    chk("wr0200_latency", lat, 2);
    chk("wr0200_we_cycles", we_n, 1);
    chk("wr0200_abus", 32'(we_a), 32'h0200);
    chk("wr0200_wbus", 32'(we_d), 32'hBEEF);
    chk("wr0200_err", 32'(err), 32'h0);

    run_single(1, 0, 16'h0200, 16'h0, lat, we_n, we_a, we_d, err, rd, pa);
    chk("rd0200_latency", lat, 3);
    chk("rd0200_rdata", 32'(rd), 32'hBEEF);

    run_single(1, 1, 16'h0FFD, 16'h1234, lat, we_n, we_a, we_d, err, rd, pa);
    chk("ro_wr_we_cycles", we_n, 0);
    chk("ro_wr_latency", lat, 2);
    chk("ro_wr_err", 32'(err), 32'h1);

    run_single(1, 0, 16'h0FFD, 16'h0, lat, we_n, we_a, we_d, err, rd, pa);
    chk("ro_rd_rdata", 32'(rd), 32'h00AA);

    run_single(1, 1, 16'h0FFC, 16'h5555, lat, we_n, we_a, we_d, err, rd, pa);
    chk("porta_err", 32'(err), 32'h0);
    chk("porta_we_cycles", we_n, 1);
    chk("porta_value", 32'(pa), 32'h5555);

    // Reset during WAIT of a data read, request held across reset.
    @(posedge clk); #1;
    data_req = 1; data_we = 0; data_addr = 16'h0200;
    @(posedge clk); @(posedge clk); #2;
    chk("mid_busy_before_rst", 32'(busy), 32'h1);
    reset = 1; #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_we", 32'(we), 32'h0);
    chk("mid_rst_data_ack", 32'(data_ack), 32'h0);
    chk("mid_rst_fetch_ack", 32'(fetch_ack), 32'h0);
    chk("mid_rst_data_err", 32'(data_err), 32'h0);
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    chk("mid_rst_abus", 32'(int_abus), 32'h0);
    chk("mid_rst_wbus", 32'(int_wbus), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    lat = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (data_ack) begin got = 1; rd = rdata; end
    end
    chk("fresh_latency", lat, 3);
    chk("fresh_rdata", 32'(rd), 32'hBEEF);
    @(posedge clk); #1;
    data_req = 0;

    // Both requesters held together: grants must alternate starting with fetch.
    g0 = glog.size();
    run_pair(2, 2, 0);
    chk("tie_count", glog.size() - g0, 4);
    for (int i = 0; i < 4; i++) begin
      if (g0 + i < glog.size()) chk("tie_order", glog[g0 + i], i % 2);
    end

    run_pair(60, 60, 1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the internal memory bus of the MMA processor. It accepts word read/write requests from the instruction-fetch path and the data (load/store) path, arbitrates between them, and drives `int_abus`/`int_wbus`/`we`. It also captures `int_rbus` with the correct one-cycle read latency. It sits between the control unit and `memory_unit`, and is the only driver of the memory bus.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `fetch_req`  in  1  fetch read request, level, held until `fetch_ack`
- `fetch_addr`  in  AW  fetch address, stable while `fetch_req`
- `fetch_ack`  out  1  one-cycle pulse; `rdata` valid in same cycle
- `data_req`  in  1  data request, level, held until `data_ack`
- `data_we`  in  1  1 = write, 0 = read
- `data_addr`  in  AW  data address
- `data_wdata`  in  DW  write data
- `data_ack`  out  1  one-cycle pulse; completes data request
- `data_err`  out  1  pulses with `data_ack` when a write targeted a read-only port
- `rdata`  out  DW  registered read data, holds until next read completes
- `busy`  out  1  high in every state except IDLE
- `we`  out  1  memory write enable
- `int_abus`  out  AW  memory address, registered
- `int_wbus`  out  DW  memory write data, registered
- `int_rbus`  in  DW  memory read data; valid one cycle after address is registered by memory

## Operation
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE: sample `fetch_req`/`data_req`.
  - With neither request, stay in IDLE with `we=0` and address held.
  - With a request, grant it via round-robin, load `int_abus`, `int_wbus` and the pending `we`, then go to ACCESS.
- Round-robin: when both requesters are pending, grant the one not granted last. After reset, fetch wins the first tie. A single requester always wins.
- ACCESS: the bus is driven for exactly one cycle.
  - Write: `we=1`; memory commits at the closing edge; next state ACK.
  - Read: `we=0`; memory latches the address at the closing edge; next state WAIT.
- WAIT: `int_rbus` holds `ram[addr]`. Capture it into `rdata` at the closing edge; next state ACK.
- ACK: assert the granted requester's ack for one cycle; `we=0`; next state IDLE.
- Requester rule: drop `req`, or present a new request, from the edge that closes the ACK cycle. A `req` still high in IDLE counts as a new transaction, so back-to-back requests are legal.
- Fetch is always a read; `data_we` is ignored on the fetch path.
- Read-only input ports are 0x0FFD (portb) and 0x0FFF (portd). A data write to either:
  - suppresses `we` in ACCESS (no memory write);
  - still produces `data_ack`, with `data_err=1`.
- Writes to 0x0FFB (PSW), 0x0FFC and 0x0FFE are legal.
- Address and data pass through unmodified. No wrap or width conversion is needed (AW=16 covers 0x0000–0xFFFF).

## Timing
- Reset values:
  - `we=0`, `int_abus=0`, `int_wbus=0`, `rdata=0`
  - `fetch_ack=0`, `data_ack=0`, `data_err=0`, `busy=0`
  - state IDLE; last-grant = data, so fetch wins the first tie
- Read latency: request sampled at edge E0, ACCESS E0→E1, WAIT E1→E2, ack high E2→E3. Ack appears 3 cycles after sampling; `rdata` is valid from E2.
- Write latency: ACCESS E0→E1 (`we` high exactly this cycle), ack E1→E2. That is 2 cycles.
- `we` is never high for more than one consecutive cycle and never outside ACCESS.
- Maximum throughput: one read per 4 cycles, one write per 3 cycles.
- Asynchronous reset mid-transaction:
  - state goes to IDLE and `we` drops immediately;
  - no ack is issued and the aborted request is not replayed;
  - a requester still holding `req` after reset is served fresh.
- A request whose `req` drops before its ack: behaviour is undefined (protocol violation). The bench flags it; the RTL need not handle it.

## Structure
- Shared package `mma_bus_pkg`:
  - FSM state typedef;
  - constants `ADDR_PSW=16'h0FFB`, `ADDR_PORTA=16'h0FFC`, `ADDR_PORTB=16'h0FFD`, `ADDR_PORTC=16'h0FFE`, `ADDR_PORTD=16'h0FFF`;
  - read-only port predicate.
- One sub-module, `mem_bus_arb`: 2-way round-robin arbiter (req[1:0], update strobe → one-hot grant, last-grant register).

## Test plan
- Fetch read at 0x0100, with the program loaded so that ram[0x0100]=0x0003 → `fetch_ack` 3 cycles after sampling, `rdata=0x0003`, `we` never high.
- Data write 0xBEEF to 0x0200, then data read of 0x0200 → `we` high exactly one cycle with `int_abus=0x0200` and `int_wbus=0xBEEF`; read returns `rdata=0xBEEF`.
- `fetch_req` and `data_req` asserted together and held for 4 transactions → grants alternate F, D, F, D; no starvation.
- Data write 0x1234 to 0x0FFD with portb=0x00AA → `we` stays 0; `data_ack` and `data_err` both pulse; a subsequent read of 0x0FFD returns 0x00AA.
- Write 0x5555 to 0x0FFC (porta) → porta=0x5555 the cycle after ACCESS; `data_err=0`.
- Reset asserted during WAIT of a read → all outputs at reset values immediately; no ack; with `req` still high after release, a fresh read completes correctly.
